// File: rtl/riscv_core_divider.sv
// rtl/riscv_core_divider.sv - iterative non-restoring RV64M divider (DIV/DIVU/REM/REMU and W forms)
//
// Ports:
//   i_div_clk          clock, rising edge
//   i_div_rstn         asynchronous active-low reset
//   i_div_srcA/srcB    dividend / divisor (XLEN)
//   i_div_control      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_div_isword       1 = 32-bit word variant
//   i_div_en           level-sensitive request
//   o_div_busy         operation in progress
//   o_div_done         one-cycle completion pulse
//   o_div_overflow     signed-overflow flag of last result
//   o_div_div_by_zero  divide-by-zero flag of last result
//   o_div_result       quotient or remainder of last completed operation
module riscv_core_divider #(
  parameter int XLEN = 64
) (
  input  logic            i_div_clk,
  input  logic            i_div_rstn,
  input  logic [XLEN-1:0] i_div_srcA,
  input  logic [XLEN-1:0] i_div_srcB,
  input  logic [1:0]      i_div_control,
  input  logic            i_div_isword,
  input  logic            i_div_en,
  output logic            o_div_busy,
  output logic            o_div_done,
  output logic            o_div_overflow,
  output logic            o_div_div_by_zero,
  output logic [XLEN-1:0] o_div_result
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic            valid_q, valid_d;
  logic            en_low_q, en_low_d;
  logic [XLEN-1:0] cache_a_q, cache_a_d;
  logic [XLEN-1:0] cache_b_q, cache_b_d;
  logic [1:0]      cache_ctl_q, cache_ctl_d;
  logic            cache_w_q, cache_w_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [XLEN+1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            flag_dz_q, flag_dz_d;
  logic            flag_ovf_q, flag_ovf_d;

  // Operand preparation from the live inputs (used only on the start edge)
  logic            signed_op;
  logic [XLEN-1:0] op_a, op_b, a_mag, b_mag;
  logic            a_neg, b_neg, in_dz, in_ovf;
  logic            start;

  always_comb begin
    signed_op = ~i_div_control[0];
    if (i_div_isword) begin
      op_a = {{HALF{signed_op & i_div_srcA[HALF-1]}}, i_div_srcA[HALF-1:0]};
      op_b = {{HALF{signed_op & i_div_srcB[HALF-1]}}, i_div_srcB[HALF-1:0]};
    end else begin
      op_a = i_div_srcA;
      op_b = i_div_srcB;
    end
    a_neg  = signed_op & op_a[XLEN-1];
    b_neg  = signed_op & op_b[XLEN-1];
    a_mag  = a_neg ? -op_a : op_a;
    b_mag  = b_neg ? -op_b : op_b;
    in_dz  = (op_b == '0);
    // After extension, both widths' most-negative value is all ones above bit HALF-1 or XLEN-1
    in_ovf = signed_op && (op_b == '1) &&
             (op_a == (i_div_isword ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                                    : {1'b1, {(XLEN-1){1'b0}}}));
    // Start unless this exact request was already served and en stayed high since
    start  = i_div_en && (!valid_q || en_low_q ||
             ({i_div_srcA, i_div_srcB, i_div_control, i_div_isword} !=
              {cache_a_q, cache_b_q, cache_ctl_q, cache_w_q}));
  end

  // One non-restoring step: shift in the next dividend bit, then subtract
  // when the partial remainder is non-negative, add when it is negative.
  logic [XLEN+1:0] rem_shift, rem_step;
  logic [XLEN-1:0] quo_step;

  always_comb begin
    rem_shift = {rem_q[XLEN:0], quo_q[XLEN-1]};
    rem_step  = rem_q[XLEN+1] ? rem_shift + {2'b00, div_q}
                              : rem_shift - {2'b00, div_q};
    quo_step  = {quo_q[XLEN-2:0], ~rem_step[XLEN+1]};
  end

  // Final result: remainder correction, sign fix-up, special cases, word extension
  logic            is_rem, calc_last;
  logic [XLEN-1:0] rem_fix, norm_res, spec_res, raw_res, fin_res;

  always_comb begin
    is_rem    = cache_ctl_q[1];
    calc_last = dz_q | ovf_q | (cnt_q == '0);
    // Final remainder lies in [-d, d); the corrected value fits in XLEN bits
    rem_fix   = rem_q[XLEN-1:0] + (rem_q[XLEN+1] ? div_q : '0);
    if (is_rem) norm_res = rem_neg_q ? -rem_fix : rem_fix;
    else        norm_res = quo_neg_q ? -quo_q : quo_q;
    // Overflow quotient equals the (extended) most-negative dividend itself
    if (dz_q) spec_res = is_rem ? opa_q : '1;
    else      spec_res = is_rem ? '0 : opa_q;
    raw_res = (dz_q | ovf_q) ? spec_res : norm_res;
    fin_res = cache_w_q ? {{HALF{raw_res[HALF-1]}}, raw_res[HALF-1:0]} : raw_res;
  end

  // FSM: state register
  always_ff @(posedge i_div_clk or negedge i_div_rstn) begin
    if (!i_div_rstn) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (calc_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_div_busy = (state_q == CALC);
    o_div_done = (state_q == DONE);
  end

  assign o_div_result      = result_q;
  assign o_div_overflow    = flag_ovf_q;
  assign o_div_div_by_zero = flag_dz_q;

  // Datapath next-state
  always_comb begin
    valid_d     = valid_q;
    en_low_d    = en_low_q;
    cache_a_d   = cache_a_q;
    cache_b_d   = cache_b_q;
    cache_ctl_d = cache_ctl_q;
    cache_w_d   = cache_w_q;
    opa_d       = opa_q;
    div_d       = div_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    flag_dz_d   = flag_dz_q;
    flag_ovf_d  = flag_ovf_q;

    case (state_q)
      IDLE: begin
        if (!i_div_en) en_low_d = 1'b1;
        if (start) begin
          valid_d     = 1'b1;
          cache_a_d   = i_div_srcA;
          cache_b_d   = i_div_srcB;
          cache_ctl_d = i_div_control;
          cache_w_d   = i_div_isword;
          opa_d       = op_a;
          div_d       = b_mag;
          rem_d       = '0;
          // Word magnitudes sit in the top half so 32 shifts consume them
          quo_d       = i_div_isword ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
          cnt_d       = i_div_isword ? CW'(HALF) : CW'(XLEN);
          quo_neg_d   = a_neg ^ b_neg;
          rem_neg_d   = a_neg;
          dz_d        = in_dz;
          ovf_d       = in_ovf;
        end
      end
      CALC: begin
        if (calc_last) begin
          result_d   = fin_res;
          flag_dz_d  = dz_q;
          flag_ovf_d = ovf_q;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    en_low_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge i_div_clk or negedge i_div_rstn) begin
    if (!i_div_rstn) begin
      valid_q     <= 1'b0;
      en_low_q    <= 1'b0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_ctl_q <= '0;
      cache_w_q   <= 1'b0;
      opa_q       <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      flag_dz_q   <= 1'b0;
      flag_ovf_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      en_low_q    <= en_low_d;
      cache_a_q   <= cache_a_d;
      cache_b_q   <= cache_b_d;
      cache_ctl_q <= cache_ctl_d;
      cache_w_q   <= cache_w_d;
      opa_q       <= opa_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      flag_dz_q   <= flag_dz_d;
      flag_ovf_q  <= flag_ovf_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_divider.sv
// tb/tb_riscv_core_divider.sv - self-checking bench for riscv_core_divider
module tb_riscv_core_divider;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] srca, srcb;
  logic [1:0]  ctl;
  logic        isword, en;
  logic        busy, done, ovf, dz;
  logic [63:0] result;

  int vectors = 0;
  int miscompares = 0;

  riscv_core_divider #(.XLEN(64)) dut (
    .i_div_clk         (clk),
    .i_div_rstn        (rstn),
    .i_div_srcA        (srca),
    .i_div_srcB        (srcb),
    .i_div_control     (ctl),
    .i_div_isword      (isword),
    .i_div_en          (en),
    .o_div_busy        (busy),
    .o_div_done        (done),
    .o_div_overflow    (ovf),
    .o_div_div_by_zero (dz),
    .o_div_result      (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics via native signed/unsigned division
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                                input logic w, output logic [63:0] res, output logic mdz,
                                output logic movf);
    logic        sg, rm;
    logic [31:0] a32, b32, r32;
    sg = ~c[0];
    rm = c[1];
    if (w) begin
      a32  = a[31:0];
      b32  = b[31:0];
      mdz  = (b32 == 32'd0);
      movf = sg && (a32 == 32'h80000000) && (b32 == 32'hFFFFFFFF);
      if (mdz)       r32 = rm ? a32 : 32'hFFFFFFFF;
      else if (movf) r32 = rm ? 32'd0 : a32;
      else if (sg)   r32 = rm ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
      else           r32 = rm ? a32 % b32 : a32 / b32;
      res = {{32{r32[31]}}, r32};
    end else begin
      mdz  = (b == 64'd0);
      movf = sg && (a == 64'h8000000000000000) && (b == '1);
      if (mdz)       res = rm ? a : '1;
      else if (movf) res = rm ? 64'd0 : a;
      else if (sg)   res = rm ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
      else           res = rm ? a % b : a / b;
    end
  endfunction

  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] c, input logic w, input bit hold);
    logic [63:0] eres;
    logic        edz, eovf, seen;
    int          lat;
    model(a, b, c, w, eres, edz, eovf);
    @(negedge clk);
    srca = a; srcb = b; ctl = c; isword = w; en = 1'b1;
    seen = 1'b0;
    lat  = 999;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    check({tag, "/done"}, 64'(seen), 64'd1);
    check({tag, "/lat<=66"}, 64'(lat <= 66), 64'd1);
    check({tag, "/res"}, result, eres);
    check({tag, "/dz"}, 64'(dz), 64'(edz));
    check({tag, "/ovf"}, 64'(ovf), 64'(eovf));
    if (!hold) en = 1'b0;
    @(negedge clk);
    check({tag, "/pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 20));
      2:       return 64'd0;
      3:       return '1;
      4:       return 64'h8000000000000000;
      5:       return {32'd0, $urandom};
      6:       return 64'h0000000080000000;
      default: return -64'($urandom_range(1, 1000));
    endcase
  endfunction

  initial begin
    int restarts;
    rstn = 1'b0; srca = '0; srcb = '0; ctl = 2'b00; isword = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/outs", {59'd0, busy, done, ovf, dz, 1'b0}, 64'd0);
    check("reset/res", result, 64'd0);
    rstn = 1'b1;

    // Directed cases
    do_op("div_neg",   64'hFFFFFFFFFFFFFFEC, 64'd6, 2'b00, 1'b0, 1'b0);
    do_op("rem_neg",   64'hFFFFFFFFFFFFFFEC, 64'd6, 2'b10, 1'b0, 1'b0);
    do_op("divu_max",  '1, 64'd2, 2'b01, 1'b0, 1'b0);
    do_op("remu_max",  '1, 64'd2, 2'b11, 1'b0, 1'b0);
    do_op("div_dz",    64'h1234, 64'd0, 2'b00, 1'b0, 1'b0);
    do_op("remu_dz",   64'h1234, 64'd0, 2'b11, 1'b0, 1'b0);
    do_op("remw_dz",   64'h80000005, 64'hABCD000000000000, 2'b10, 1'b1, 1'b0);
    do_op("div_ovf",   64'h8000000000000000, '1, 2'b00, 1'b0, 1'b0);
    do_op("rem_ovf",   64'h8000000000000000, '1, 2'b10, 1'b0, 1'b0);
    do_op("divw_ovf",  64'h80000000, 64'hFFFFFFFF, 2'b00, 1'b1, 1'b0);
    do_op("divuw",     64'hFFFFFFFE, 64'd1, 2'b01, 1'b1, 1'b0);
    do_op("div_same",  64'hFFFFFFFFFFFFFFEC, 64'd6, 2'b00, 1'b0, 1'b0);

    // Reset in the middle of a calculation
    @(negedge clk);
    srca = 64'd1000; srcb = 64'd7; ctl = 2'b01; isword = 1'b0; en = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst/busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    check("midrst/outs", {60'd0, busy, done, ovf, dz}, 64'd0);
    check("midrst/res", result, 64'd0);
    en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    do_op("after_rst", 64'd1000, 64'd7, 2'b01, 1'b0, 1'b0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rnd%0d", i), rnd_operand(), rnd_operand(), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'b0);
    end

    // Back-to-back with en held high: unchanged inputs must not restart
    for (int i = 0; i < 4; i++) begin
      do_op($sformatf("b2b%0d", i), rnd_operand(), 64'(i + 3), 2'($urandom_range(0, 3)),
            1'b0, 1'b1);
      restarts = 0;
      for (int k = 0; k < 66; k++) begin
        @(negedge clk);
        if (busy || done) restarts++;
      end
      check($sformatf("b2b%0d/norestart", i), 64'(restarts), 64'd0);
    end
    en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
